fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 redirect_valid  input  1  taken jump/branch from the jump/branch stage.
REQ-005 redirect_pc  input  32  target PC from the jump/branch stage.
REQ-006 imem_req_valid  output  1  instruction-memory request valid.
REQ-007 imem_req_ready  input  1  memory accepts request.
REQ-008 imem_req_addr  output  32  fetch address.
REQ-009 imem_rsp_valid  input  1  instruction word returned (always accepted).
REQ-010 imem_rsp_data  input  32  instruction word.
REQ-011 dec_valid  output  1  instruction available to decode.
REQ-012 dec_ready  input  1  decode accepts instruction.
REQ-013 dec_instr  output  32  instruction to decode.
REQ-014 dec_pc  output  32  PC of dec_instr.

Function
REQ-015 The block SHALL hold registers pc, req_pc, state, drop, buf_valid, buf_instr and buf_pc.
REQ-016 The FSM SHALL have exactly two states: REQ (may issue) and WAIT (one request outstanding); at most one request SHALL be in flight.
REQ-017 In REQ, imem_req_valid SHALL be (!buf_valid || dec_ready) && !rst, and imem_req_addr SHALL equal pc.
REQ-018 On a request handshake, req_pc <= pc, pc <= pc + 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), and state <= WAIT.
REQ-019 In WAIT, imem_req_valid SHALL be 0; on imem_rsp_valid, state <= REQ, and buf_valid <= 1, buf_instr <= imem_rsp_data, buf_pc <= req_pc unless the response is dropped.
REQ-020 dec_valid SHALL equal buf_valid, and dec_instr/dec_pc SHALL equal buf_instr/buf_pc; buf_valid SHALL clear on dec_valid && dec_ready unless the buffer reloads in the same cycle.
REQ-021 dec_instr and dec_pc SHALL remain stable while dec_valid && !dec_ready.
REQ-022 On redirect_valid: pc <= {redirect_pc[31:2], 2'b00}, buf_valid <= 0 the next cycle, and redirect SHALL take priority over every other pc update.
REQ-023 A redirect in WAIT without imem_rsp_valid SHALL set drop; the next response SHALL be discarded, drop SHALL clear, and state <= REQ.
REQ-024 A redirect coinciding with imem_rsp_valid SHALL discard that response, leave drop at 0, and set state <= REQ.
REQ-025 A redirect coinciding with a request handshake SHALL set drop and state <= WAIT; that request's address SHALL be the pre-redirect pc.
REQ-026 A redirect coinciding with a dec handshake SHALL still count as a consumed instruction, with the buffer cleared.
REQ-027 Latency from the request handshake in cycle N with the response in N+1 SHALL be dec_valid high in N+2; peak throughput SHALL be one instruction per 2 cycles.
REQ-028 The redirect-to-first-new-request latency SHALL be 1 cycle when not blocked by an outstanding request.

Reset
REQ-029 While rst is high at a clock edge: pc <= RESET_PC, state <= REQ, drop <= 0, buf_valid <= 0, and buf_instr, buf_pc, req_pc <= 0.
REQ-030 imem_req_valid and dec_valid SHALL be 0 during any cycle in which rst is high.
REQ-031 Reset asserted while a request is outstanding SHALL leave drop at 0; the environment SHALL quiesce memory across reset.

Structure
REQ-032 The fetch_state_t enum (REQ, WAIT), the RESET_PC default and XLEN_I=32 SHALL live in the shared riscv package.
REQ-033 The output buffer and FSM SHALL be inline, with no sub-module required.

Verification
REQ-034 Reset, then memory ready and 1-cycle response -> addresses 0x0, 0x4, 0x8; dec_pc 0x0, 0x4, 0x8 with matching instr; dec_valid first high 2 cycles after reset release.
REQ-035 dec_ready held low 5 cycles with buffer full -> imem_req_valid stays 0 and dec_instr/dec_pc stay stable; on release, fetch resumes at the next pc.
REQ-036 Redirect to 0x100 while WAIT on addr 0x8, response 2 cycles later -> the 0x8 response is dropped, next request addr 0x100, next dec_pc 0x100.
REQ-037 Redirect to 0x203 coinciding with a response -> response discarded, next request addr 0x200, no drop pending.
REQ-038 Redirect in the same cycle as a request handshake at 0x40 -> the 0x40 response is dropped, next request addr is the redirect target.
REQ-039 RESET_PC=32'hFFFF_FFFC -> first fetch 0xFFFF_FFFC, second fetch 0x0000_0000.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V fetch types, widths and helpers
package riscv_pkg;

    localparam int XLEN_I = 32;
    localparam logic [XLEN_I-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        REQ,
        WAIT
    } fetch_state_t;

    // Instructions are word aligned; low address bits of a target are ignored.
    function automatic logic [XLEN_I-1:0] align_pc(input logic [XLEN_I-1:0] pc);
        return pc & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - redirect, instruction-memory and decode handshakes of the fetch unit
interface fetch_unit_if;
    import riscv_pkg::*;

    logic              redirect_valid;
    logic [XLEN_I-1:0] redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN_I-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [XLEN_I-1:0] imem_rsp_data;
    logic              dec_valid;
    logic              dec_ready;
    logic [XLEN_I-1:0] dec_instr;
    logic [XLEN_I-1:0] dec_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
        output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
        input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc
    );

endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with one-entry decode buffer
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN_I-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    fetch_state_t      state_q, state_d;
    logic [XLEN_I-1:0] pc_q, pc_d;
    logic [XLEN_I-1:0] req_pc_q, req_pc_d;
    logic              drop_q, drop_d;
    logic              buf_valid_q, buf_valid_d;
    logic [XLEN_I-1:0] buf_instr_q, buf_instr_d;
    logic [XLEN_I-1:0] buf_pc_q, buf_pc_d;

    logic req_fire;
    logic rsp_seen;
    logic dec_fire;

    // A new request is only issued if its response will find room in the buffer.
    assign bus.imem_req_valid = (state_q == REQ) && (!buf_valid_q || bus.dec_ready) && !rst;
    assign bus.imem_req_addr  = pc_q;
    assign bus.dec_valid      = buf_valid_q && !rst;
    assign bus.dec_instr      = buf_instr_q;
    assign bus.dec_pc         = buf_pc_q;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp_seen = (state_q == WAIT) && bus.imem_rsp_valid;
    assign dec_fire = bus.dec_valid && bus.dec_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        drop_d      = drop_q;
        buf_valid_d = buf_valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;

        if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 32'd4;
            state_d  = WAIT;
        end
        if (rsp_seen) begin
            state_d = REQ;
            drop_d  = 1'b0;
        end
        // The in-flight request (old or just issued) belongs to the wrong path.
        if (bus.redirect_valid) begin
            pc_d = align_pc(bus.redirect_pc);
            if (((state_q == WAIT) && !rsp_seen) || req_fire) begin
                drop_d = 1'b1;
            end
        end

        if (bus.redirect_valid) begin
            buf_valid_d = 1'b0;
        end else if (rsp_seen && !drop_q) begin
            buf_valid_d = 1'b1;
            buf_instr_d = bus.imem_rsp_data;
            buf_pc_d    = req_pc_q;
        end else if (dec_fire) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= REQ;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            drop_q      <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            drop_q      <= drop_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if b0();
    fetch_unit_if b1();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    int total = 0;
    int bad   = 0;

    // Memory for dut0: answers each accepted request after mem_delay cycles with addr ^ 0xDEAD0000.
    int          mem_delay = 1;
    int          cnt = 0;
    logic        hs_n = 1'b0;
    logic [31:0] hs_addr_n = '0;
    logic [31:0] pend_addr = '0;

    always @(negedge clk) begin
        hs_n      = b0.imem_req_valid && b0.imem_req_ready;
        hs_addr_n = b0.imem_req_addr;
    end

    always @(posedge clk) begin
        #1;
        b0.imem_rsp_valid = 1'b0;
        if (rst) begin
            cnt = 0;
        end else begin
            if (hs_n) begin
                pend_addr = hs_addr_n;
                cnt       = mem_delay;
            end
            if (cnt > 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    b0.imem_rsp_valid = 1'b1;
                    b0.imem_rsp_data  = pend_addr ^ 32'hDEAD_0000;
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #2;
        b0.redirect_valid = 1'b0;
        b1.redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        b0.imem_req_ready = 1'b1;
        b0.dec_ready      = 1'b1;
        b1.imem_req_ready = 1'b0;
        b1.dec_ready      = 1'b0;
        b1.imem_rsp_valid = 1'b0;
        mem_delay = 1;
        next();
        next();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        next();
        #1;
        total++; if (b0.imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", b0.imem_req_valid); end
        total++; if (b0.dec_valid !== 1'b0) begin bad++; $display("FAIL rst_dec_valid got=%b exp=0", b0.dec_valid); end
        total++; if (b1.imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid_1 got=%b exp=0", b1.imem_req_valid); end
        do_reset();
        #1;
        total++; if (b0.imem_req_valid !== 1'b1) begin bad++; $display("FAIL post_rst_req_valid got=%b exp=1", b0.imem_req_valid); end
        total++; if (b0.imem_req_addr !== 32'h0) begin bad++; $display("FAIL post_rst_addr got=%h exp=00000000", b0.imem_req_addr); end
        total++; if (b0.dec_valid !== 1'b0) begin bad++; $display("FAIL post_rst_dec_valid got=%b exp=0", b0.dec_valid); end
    endtask

    task automatic test_basic();
        logic [31:0] e;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            next();
            #1;
            total++; if (b0.dec_valid !== 1'b0 || b0.imem_req_valid !== 1'b0) begin bad++; $display("FAIL basic_wait%0d got dv=%b rv=%b exp 0 0", k, b0.dec_valid, b0.imem_req_valid); end
            next();
            #1;
            e = 32'(4 * k);
            total++; if (b0.dec_valid !== 1'b1) begin bad++; $display("FAIL basic_dv%0d got=%b exp=1", k, b0.dec_valid); end
            total++; if (b0.dec_pc !== e) begin bad++; $display("FAIL basic_pc%0d got=%h exp=%h", k, b0.dec_pc, e); end
            total++; if (b0.dec_instr !== (e ^ 32'hDEAD_0000)) begin bad++; $display("FAIL basic_instr%0d got=%h exp=%h", k, b0.dec_instr, e ^ 32'hDEAD_0000); end
            total++; if (b0.imem_req_addr !== e + 32'd4 || b0.imem_req_valid !== 1'b1) begin bad++; $display("FAIL basic_addr%0d got=%h exp=%h", k, b0.imem_req_addr, e + 32'd4); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        next();
        next();
        b0.dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (b0.imem_req_valid !== 1'b0) begin bad++; $display("FAIL stall_req%0d got=%b exp=0", i, b0.imem_req_valid); end
            total++; if (b0.dec_valid !== 1'b1 || b0.dec_pc !== 32'h0 || b0.dec_instr !== 32'hDEAD_0000) begin bad++; $display("FAIL stall_hold%0d got dv=%b pc=%h instr=%h exp 1 00000000 dead0000", i, b0.dec_valid, b0.dec_pc, b0.dec_instr); end
            next();
        end
        b0.dec_ready = 1'b1;
        #1;
        total++; if (b0.imem_req_valid !== 1'b1 || b0.imem_req_addr !== 32'h4) begin bad++; $display("FAIL stall_resume got rv=%b addr=%h exp 1 00000004", b0.imem_req_valid, b0.imem_req_addr); end
        next();
        #1;
        total++; if (b0.dec_valid !== 1'b0) begin bad++; $display("FAIL stall_consumed got=%b exp=0", b0.dec_valid); end
        next();
        #1;
        total++; if (b0.dec_pc !== 32'h4 || b0.dec_instr !== 32'hDEAD_0004) begin bad++; $display("FAIL stall_next got pc=%h instr=%h exp 00000004 dead0004", b0.dec_pc, b0.dec_instr); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        next(); next(); next(); next();
        mem_delay = 3;
        #1;
        total++; if (b0.imem_req_valid !== 1'b1 || b0.imem_req_addr !== 32'h8) begin bad++; $display("FAIL rw_addr8 got rv=%b addr=%h exp 1 00000008", b0.imem_req_valid, b0.imem_req_addr); end
        next();
        b0.redirect_valid = 1'b1;
        b0.redirect_pc    = 32'h100;
        #1;
        total++; if (b0.imem_req_valid !== 1'b0) begin bad++; $display("FAIL rw_wait got=%b exp=0", b0.imem_req_valid); end
        next();
        next();
        mem_delay = 1;
        #1;
        total++; if (b0.dec_valid !== 1'b0 || b0.imem_req_valid !== 1'b0) begin bad++; $display("FAIL rw_drop got dv=%b rv=%b exp 0 0", b0.dec_valid, b0.imem_req_valid); end
        next();
        #1;
        total++; if (b0.imem_req_valid !== 1'b1 || b0.imem_req_addr !== 32'h100 || b0.dec_valid !== 1'b0) begin bad++; $display("FAIL rw_newreq got rv=%b addr=%h dv=%b exp 1 00000100 0", b0.imem_req_valid, b0.imem_req_addr, b0.dec_valid); end
        next();
        next();
        #1;
        total++; if (b0.dec_valid !== 1'b1 || b0.dec_pc !== 32'h100 || b0.dec_instr !== 32'hDEAD_0100) begin bad++; $display("FAIL rw_dec got dv=%b pc=%h instr=%h exp 1 00000100 dead0100", b0.dec_valid, b0.dec_pc, b0.dec_instr); end
    endtask

    task automatic test_redirect_rsp();
        do_reset();
        next();
        b0.redirect_valid = 1'b1;
        b0.redirect_pc    = 32'h203;
        next();
        #1;
        total++; if (b0.imem_req_valid !== 1'b1 || b0.imem_req_addr !== 32'h200 || b0.dec_valid !== 1'b0) begin bad++; $display("FAIL rr_newreq got rv=%b addr=%h dv=%b exp 1 00000200 0", b0.imem_req_valid, b0.imem_req_addr, b0.dec_valid); end
        next();
        next();
        #1;
        total++; if (b0.dec_valid !== 1'b1 || b0.dec_pc !== 32'h200 || b0.dec_instr !== 32'hDEAD_0200) begin bad++; $display("FAIL rr_nodrop got dv=%b pc=%h instr=%h exp 1 00000200 dead0200", b0.dec_valid, b0.dec_pc, b0.dec_instr); end
    endtask

    task automatic test_redirect_hs();
        do_reset();
        b0.imem_req_ready = 1'b0;
        b0.redirect_valid = 1'b1;
        b0.redirect_pc    = 32'h40;
        next();
        b0.imem_req_ready = 1'b1;
        b0.redirect_valid = 1'b1;
        b0.redirect_pc    = 32'h80;
        #1;
        total++; if (b0.imem_req_valid !== 1'b1 || b0.imem_req_addr !== 32'h40) begin bad++; $display("FAIL rh_latency got rv=%b addr=%h exp 1 00000040", b0.imem_req_valid, b0.imem_req_addr); end
        next();
        #1;
        total++; if (b0.imem_req_valid !== 1'b0) begin bad++; $display("FAIL rh_wait got=%b exp=0", b0.imem_req_valid); end
        next();
        #1;
        total++; if (b0.imem_req_valid !== 1'b1 || b0.imem_req_addr !== 32'h80 || b0.dec_valid !== 1'b0) begin bad++; $display("FAIL rh_newreq got rv=%b addr=%h dv=%b exp 1 00000080 0", b0.imem_req_valid, b0.imem_req_addr, b0.dec_valid); end
        next();
        next();
        #1;
        total++; if (b0.dec_valid !== 1'b1 || b0.dec_pc !== 32'h80 || b0.dec_instr !== 32'hDEAD_0080) begin bad++; $display("FAIL rh_dec got dv=%b pc=%h instr=%h exp 1 00000080 dead0080", b0.dec_valid, b0.dec_pc, b0.dec_instr); end
    endtask

    task automatic test_redirect_dec();
        do_reset();
        next();
        next();
        b0.redirect_valid = 1'b1;
        b0.redirect_pc    = 32'h300;
        next();
        #1;
        total++; if (b0.dec_valid !== 1'b0 || b0.imem_req_valid !== 1'b0) begin bad++; $display("FAIL rd_clear got dv=%b rv=%b exp 0 0", b0.dec_valid, b0.imem_req_valid); end
        next();
        #1;
        total++; if (b0.imem_req_valid !== 1'b1 || b0.imem_req_addr !== 32'h300 || b0.dec_valid !== 1'b0) begin bad++; $display("FAIL rd_newreq got rv=%b addr=%h dv=%b exp 1 00000300 0", b0.imem_req_valid, b0.imem_req_addr, b0.dec_valid); end
        next();
        next();
        #1;
        total++; if (b0.dec_pc !== 32'h300 || b0.dec_instr !== 32'hDEAD_0300) begin bad++; $display("FAIL rd_dec got pc=%h instr=%h exp 00000300 dead0300", b0.dec_pc, b0.dec_instr); end
    endtask

    task automatic test_wrap();
        do_reset();
        b1.imem_req_ready = 1'b1;
        b1.dec_ready      = 1'b1;
        #1;
        total++; if (b1.imem_req_valid !== 1'b1 || b1.imem_req_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_first got rv=%b addr=%h exp 1 fffffffc", b1.imem_req_valid, b1.imem_req_addr); end
        next();
        b1.imem_rsp_valid = 1'b1;
        b1.imem_rsp_data  = 32'h1234_5678;
        next();
        b1.imem_rsp_valid = 1'b0;
        #1;
        total++; if (b1.imem_req_valid !== 1'b1 || b1.imem_req_addr !== 32'h0) begin bad++; $display("FAIL wrap_second got rv=%b addr=%h exp 1 00000000", b1.imem_req_valid, b1.imem_req_addr); end
        total++; if (b1.dec_valid !== 1'b1 || b1.dec_pc !== 32'hFFFF_FFFC || b1.dec_instr !== 32'h1234_5678) begin bad++; $display("FAIL wrap_dec got dv=%b pc=%h instr=%h exp 1 fffffffc 12345678", b1.dec_valid, b1.dec_pc, b1.dec_instr); end
    endtask

    initial begin
        b0.redirect_valid = 1'b0;
        b0.redirect_pc    = '0;
        b0.imem_req_ready = 1'b1;
        b0.imem_rsp_valid = 1'b0;
        b0.imem_rsp_data  = '0;
        b0.dec_ready      = 1'b1;
        b1.redirect_valid = 1'b0;
        b1.redirect_pc    = '0;
        b1.imem_req_ready = 1'b0;
        b1.imem_rsp_valid = 1'b0;
        b1.imem_rsp_data  = '0;
        b1.dec_ready      = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_rsp();
        test_redirect_hs();
        test_redirect_dec();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
